// File: rtl/arb_pkg.sv
// Shared encodings for the two-source select arbiter: mux select codes and
// the output holding-stage state.
package arb_pkg;

    localparam logic [1:0] SEL_D0   = 2'b00;
    localparam logic [1:0] SEL_D1   = 2'b01;
    localparam logic [1:0] SEL_IDLE = 2'b10;

    typedef enum logic {EMPTY, FULL} out_state_t;

endpackage

// File: rtl/mux_2to1.sv
// Companion datapath mux steered by the arbiter; the idle select drives zero.
module mux_2to1 #(
    parameter int N = 2
) (
    input  logic [1:0]   sel,
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    output logic [N-1:0] y
);

    always_comb begin
        case (sel)
            2'b00:   y = d0;
            2'b01:   y = d1;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter between two valid/ready sources that steers an external
// mux and captures its result in a 1-deep output register.
module mux_sel_arbiter
    import arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic         req1_valid,
    output logic         req1_ready,
    output logic [1:0]   sel,
    input  logic [N-1:0] mux_y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [7:0]   grant_cnt0,
    output logic [7:0]   grant_cnt1
);

    out_state_t state;
    logic       prio;
    logic       accept;
    logic       grant0;
    logic       grant1;

    // Grants are masked during reset so nothing transfers in the reset cycle.
    always_comb begin
        accept = (state == EMPTY) || out_ready;
        grant0 = !rst && accept && req0_valid && (!req1_valid || !prio);
        grant1 = !rst && accept && req1_valid && (!req0_valid || prio);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign sel        = grant0 ? SEL_D0 : (grant1 ? SEL_D1 : SEL_IDLE);
    assign out_valid  = (state == FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            prio       <= 1'b0;
            out_data   <= '0;
            grant_cnt0 <= 8'd0;
            grant_cnt1 <= 8'd0;
        end else begin
            if (grant0 || grant1) begin
                out_data <= mux_y;
                state    <= FULL;
                // Priority passes to whichever source was not just served.
                prio     <= grant0;
                if (grant0)
                    grant_cnt0 <= grant_cnt0 + 8'd1;
                else
                    grant_cnt1 <= grant_cnt1 + 8'd1;
            end else if (state == FULL && out_ready) begin
                state <= EMPTY;
            end
        end
    end

endmodule
